cp0_unit: RTL and testbench

- Coprocessor-0 for the exception-capable MIPS pipeline.
- Sits at the M stage. It consumes the exception bundle that the pipeline registers carry forward: PC, BDIn, ExcCode, Error, eret and mtc0.
- Produces Req, the flush/redirect request that clears every pipeline register and steers the PC to the handler.
- Produces EPC for eret, and serves mfc0 reads.

---
 rtl/cp0_unit_pkg.sv | 33 +++
 rtl/cp0_unit_if.sv | 31 +++
 rtl/cp0_int_arb.sv | 27 ++
 rtl/cp0_unit.sv | 124 ++++++++++++
 tb/tb_cp0_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/cp0_unit_pkg.sv
// rtl/cp0_unit_pkg.sv - shared CP0 register numbers, field positions and exception codes
// Purpose: constants shared by cp0_unit, cp0_int_arb and cp0_unit_if.
// Contents: register numbers (SR/Cause/EPC/PRId), field bit positions, ExcCode values.
package cp0_unit_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR fields
  localparam int SR_IM_HI   = 15;
  localparam int SR_IM_LO   = 10;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IE_BIT  = 0;

  // Cause fields
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - pipeline <-> CP0 bundle with master/slave modports
// Purpose: carries the M-stage exception bundle, mtc0/mfc0 access and CP0 results.
// master: pipeline side (drives A1/A2/DIn/mtc0_M/eret_M/PC_M/BDIn_M/Error_M/ExcCode_M/HWInt).
// slave : cp0_unit side (drives DOut/EPCOut/HandlerPC/Req/EXL).
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        mtc0_M;
  logic        eret_M;
  logic [31:0] PC_M;
  logic        BDIn_M;
  logic        Error_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic [31:0] HandlerPC;
  logic        Req;
  logic        EXL;

  modport master (
    output A1, A2, DIn, mtc0_M, eret_M, PC_M, BDIn_M, Error_M, ExcCode_M, HWInt,
    input  DOut, EPCOut, HandlerPC, Req, EXL
  );

  modport slave (
    input  A1, A2, DIn, mtc0_M, eret_M, PC_M, BDIn_M, Error_M, ExcCode_M, HWInt,
    output DOut, EPCOut, HandlerPC, Req, EXL
  );
endinterface

// File: rtl/cp0_int_arb.sv
// rtl/cp0_int_arb.sv - combinational interrupt/exception request arbiter
// Purpose: decides whether the M-stage row traps this cycle and which ExcCode is logged.
// Inputs : hwint_i, im_i, ie_i, exl_i, error_i, exc_code_i.
// Outputs: int_req_o, exc_req_o, req_o, sel_code_o.
module cp0_int_arb
  import cp0_unit_pkg::*;
(
  input  logic [5:0] hwint_i,
  input  logic [5:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic       error_i,
  input  logic [4:0] exc_code_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic       req_o,
  output logic [4:0] sel_code_o
);

  // EXL masks both sources so a handler is never re-entered before eret.
  assign int_req_o  = ie_i & ~exl_i & (|(hwint_i & im_i));
  assign exc_req_o  = error_i & ~exl_i;
  assign req_o      = int_req_o | exc_req_o;
  // An interrupt wins over a same-cycle exception; the exception re-raises after eret.
  assign sel_code_o = int_req_o ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor 0 at the M stage
// Purpose: SR/Cause/EPC/PRId registers, trap request, EPC capture, mfc0 reads.
// Ports  : clk, reset (async active-low), bus (cp0_unit_if.slave: exception bundle in,
//          DOut/EPCOut/HandlerPC/Req/EXL out).
// Option : CP0_EPC_FWD_EN forwards an in-flight mtc0 EPC write onto EPCOut.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h2022_0B07,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  cp0_unit_if.slave     bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req, exc_req, req;
  logic [4:0]  sel_code;
  logic [31:0] trap_pc;
  logic [31:0] sr_word, cause_word, rd_data, epc_out;

  cp0_int_arb u_arb (
    .hwint_i    (bus.HWInt),
    .im_i       (im_q),
    .ie_i       (ie_q),
    .exl_i      (exl_q),
    .error_i    (bus.Error_M),
    .exc_code_i (bus.ExcCode_M),
    .int_req_o  (int_req),
    .exc_req_o  (exc_req),
    .req_o      (req),
    .sel_code_o (sel_code)
  );

  // A delay-slot row restarts at its branch so the branch re-executes on return.
  always_comb begin
    trap_pc = bus.BDIn_M ? (bus.PC_M - 32'd4) : bus.PC_M;
    trap_pc = {trap_pc[31:2], 2'b00};
  end

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = bus.HWInt;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = bus.BDIn_M;
      exc_d = sel_code;
      epc_d = trap_pc;
    end else if (bus.eret_M) begin
      exl_d = 1'b0;
    end else if (bus.mtc0_M) begin
      case (bus.A2)
        CP0_SR: begin
          im_d  = bus.DIn[SR_IM_HI:SR_IM_LO];
          exl_d = bus.DIn[SR_EXL_BIT];
          ie_d  = bus.DIn[SR_IE_BIT];
        end
        CP0_EPC: epc_d = bus.DIn;
        default: ;  // Cause is read-only to software; others ignored
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};

  always_comb begin
    case (bus.A1)
      CP0_SR:    rd_data = sr_word;
      CP0_CAUSE: rd_data = cause_word;
      CP0_EPC:   rd_data = epc_q;
      CP0_PRID:  rd_data = PRID_VAL;
      default:   rd_data = 32'b0;
    endcase
  end

`ifdef CP0_EPC_FWD_EN
  // Lets an eret resolved in D pick up an EPC being written by mtc0 in M.
  assign epc_out = (bus.mtc0_M && (bus.A2 == CP0_EPC) && !req) ? bus.DIn : epc_q;
`else
  assign epc_out = epc_q;
`endif

  // Outputs are gated by reset so Req drops immediately when reset asserts mid-trap.
  assign bus.Req       = req & reset;
  assign bus.EXL       = exl_q;
  assign bus.DOut      = reset ? rd_data : 32'b0;
  assign bus.EPCOut    = reset ? epc_out : 32'b0;
  assign bus.HandlerPC = HANDLER_PC;

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - self-checking bench for cp0_unit
module tb_cp0_unit;

  localparam logic [31:0] PRID    = 32'h2022_0B07;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cp0_unit_if cif ();

  cp0_unit #(.PRID_VAL(PRID), .HANDLER_PC(HANDLER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: whole-register words, updated from the rules directly.
  logic [31:0] m_sr = 0, m_cause = 0, m_epc = 0;
  logic        m_int, m_exc, m_req;

  always_comb begin
    m_int = m_sr[0] && !m_sr[1] && ((cif.HWInt & m_sr[15:10]) != 6'd0);
    m_exc = cif.Error_M && !m_sr[1];
    m_req = m_int || m_exc;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sr    <= 0;
      m_cause <= 0;
      m_epc   <= 0;
    end else if (m_req) begin
      m_sr    <= m_sr | 32'h2;
      m_cause <= ({31'b0, cif.BDIn_M} << 31) | ({26'b0, cif.HWInt} << 10)
               | ({27'b0, (m_int ? 5'd0 : cif.ExcCode_M)} << 2);
      m_epc   <= (cif.BDIn_M ? cif.PC_M - 4 : cif.PC_M) & 32'hFFFF_FFFC;
    end else begin
      m_cause <= (m_cause & ~32'h0000_FC00) | ({26'b0, cif.HWInt} << 10);
      if (cif.eret_M)
        m_sr <= m_sr & ~32'h2;
      else if (cif.mtc0_M && cif.A2 == 5'd12)
        m_sr <= cif.DIn & 32'h0000_FC03;
      else if (cif.mtc0_M && cif.A2 == 5'd14)
        m_epc <= cif.DIn;
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e_epc;
    e_epc = m_epc;
`ifdef CP0_EPC_FWD_EN
    if (cif.mtc0_M && cif.A2 == 5'd14 && !m_req) e_epc = cif.DIn;
`endif
    chk("cyc_req",   {31'b0, cif.Req},  reset ? {31'b0, m_req} : 32'h0);
    chk("cyc_exl",   {31'b0, cif.EXL},  {31'b0, m_sr[1]});
    chk("cyc_dout",  cif.DOut,          reset ? m_read(cif.A1) : 32'h0);
    chk("cyc_epc",   cif.EPCOut,        reset ? e_epc : 32'h0);
    chk("cyc_hpc",   cif.HandlerPC,     HANDLER);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cif.mtc0_M = 0; cif.eret_M = 0; cif.Error_M = 0; cif.BDIn_M = 0;
    cif.ExcCode_M = 0; cif.A2 = 0; cif.DIn = 0;
  endtask

  initial begin
    cif.A1 = 0; cif.HWInt = 0; cif.PC_M = 32'h3000;
    idle();

    // reset outputs
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, cif.Req}, 32'h0);
    chk("rst_exl", {31'b0, cif.EXL}, 32'h0);

    next(); reset = 1;
    cif.A1 = 12; #1 chk("rd_sr0", cif.DOut, 32'h0);
    cif.A1 = 13; #1 chk("rd_cause0", cif.DOut, 32'h0);
    cif.A1 = 14; #1 chk("rd_epc0", cif.DOut, 32'h0);
    cif.A1 = 15; #1 chk("rd_prid", cif.DOut, 32'h2022_0B07);
    chk("rd_req0", {31'b0, cif.Req}, 32'h0);

    // enable all interrupt lines, then raise line 2
    next(); cif.mtc0_M = 1; cif.A2 = 12; cif.DIn = 32'h0000_FC01;
    next(); idle(); cif.HWInt = 6'b000100; cif.PC_M = 32'h3008;
    #1 chk("int_req", {31'b0, cif.Req}, 32'h1);
    next(); cif.A1 = 14;
    #1 chk("int_epc", cif.DOut, 32'h0000_3008);
    cif.A1 = 13; #1 chk("int_cause", cif.DOut, 32'h0000_1000);
    chk("int_exl", {31'b0, cif.EXL}, 32'h1);

    // EXL masks interrupt and exception
    cif.Error_M = 1; cif.ExcCode_M = 12;
    #1 chk("exl_mask", {31'b0, cif.Req}, 32'h0);
    next(); idle(); cif.eret_M = 1;
    next(); idle();
    #1 chk("eret_exl", {31'b0, cif.EXL}, 32'h0);
    chk("eret_rereq", {31'b0, cif.Req}, 32'h1);
    next(); cif.HWInt = 0; cif.eret_M = 1;
    next(); idle();

    // overflow in a delay slot
    cif.Error_M = 1; cif.ExcCode_M = 12; cif.PC_M = 32'h3010; cif.BDIn_M = 1;
    #1 chk("ov_req", {31'b0, cif.Req}, 32'h1);
    next(); idle(); cif.A1 = 14;
    #1 chk("ov_epc", cif.DOut, 32'h0000_300C);
    cif.A1 = 13; #1 chk("ov_cause", cif.DOut, 32'h8000_0030);
    next(); cif.eret_M = 1;
    next(); idle();

    // trap suppresses same-row mtc0 to EPC
    cif.Error_M = 1; cif.ExcCode_M = 4; cif.PC_M = 32'h3020;
    cif.mtc0_M = 1; cif.A2 = 14; cif.DIn = 32'hDEAD_BEEC;
    next(); idle(); cif.A1 = 14;
    #1 chk("sup_epc", cif.DOut, 32'h0000_3020);
    next(); cif.eret_M = 1;
    next(); idle();

    // Cause is not writable; IP follows HWInt
    cif.mtc0_M = 1; cif.A2 = 12; cif.DIn = 32'h0;
    next(); cif.A2 = 13; cif.DIn = 32'hFFFF_FFFF; cif.HWInt = 6'b100001;
    next(); idle(); cif.A1 = 13;
    #1 chk("cause_ro", cif.DOut, 32'h0000_8410);

    // EPC write visibility
    cif.mtc0_M = 1; cif.A2 = 14; cif.DIn = 32'h0000_4000;
`ifdef CP0_EPC_FWD_EN
    #1 chk("epc_fwd", cif.EPCOut, 32'h0000_4000);
`else
    #1 chk("epc_nofwd", cif.EPCOut, 32'h0000_3020);
`endif
    next(); idle();
    #1 chk("epc_wr", cif.EPCOut, 32'h0000_4000);

    // asynchronous reset in the middle of a trap
    next(); cif.Error_M = 1; cif.ExcCode_M = 8;
    #1 chk("ar_req_pre", {31'b0, cif.Req}, 32'h1);
    reset = 0;
    #1 chk("ar_req", {31'b0, cif.Req}, 32'h0);
    chk("ar_epc", cif.EPCOut, 32'h0);
    next(); idle();
    next(); reset = 1; cif.A1 = 14;
    #1 chk("ar_epc_rd", cif.DOut, 32'h0);
    repeat (2) next();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
